// File: rtl/fifo_pkg.sv
// Shared constants for the watermark FIFO: read-mode selectors for the FWFT parameter.
package fifo_pkg;

    localparam int FWFT_MODE = 1;
    localparam int REG_MODE  = 0;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping index counter for the FIFO storage array. It steps 0..MAX and returns to 0.
// The wrap is an explicit compare against MAX, so any depth works, not only powers of two.
module fifo_wrap_ptr #(
    parameter int MAX   = 15,
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // Flush returns the pointer to slot 0; otherwise each accepted access advances it by one slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == WIDTH'(MAX)) ? '0 : ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_wm.sv
// Synchronous FIFO with any depth and programmable high/low watermark flags.
// It also has sticky overflow/underflow flags, a synchronous flush and a selectable read mode:
// first-word-fall-through or registered.
module fifo_wm
    import fifo_pkg::*;
#(
    parameter int   DATA_WIDTH = 32,
    parameter int   DEPTH      = 16,
    parameter int   FWFT       = FWFT_MODE,
    localparam int  CNT_BITS   = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  clear,
    input  logic                  WEN,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  REN,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic [CNT_BITS-1:0]   hi_mark,
    input  logic [CNT_BITS-1:0]   lo_mark,
    input  logic                  err_clr,
    output logic [CNT_BITS-1:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  above_hi,
    output logic                  below_lo,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // The full and empty flags come from the registered count. A full FIFO therefore
    // refuses a write even when a read frees a slot on the same edge.
    assign empty    = (count == '0);
    assign full     = (count == CNT_BITS'(DEPTH));
    assign wr_acc   = WEN & ~full & ~clear;
    assign rd_acc   = REN & ~empty & ~clear;
    assign above_hi = (count >= hi_mark);
    assign below_lo = (count <= lo_mark);

    fifo_wrap_ptr #(.MAX(DEPTH - 1), .WIDTH(PTR_BITS)) u_wr_ptr (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (clear),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.MAX(DEPTH - 1), .WIDTH(PTR_BITS)) u_rd_ptr (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (clear),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // Occupancy tracks accepted writes minus accepted reads; a simultaneous pair cancels out.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + CNT_BITS'(1);
        end else if (rd_acc && !wr_acc) begin
            count <= count - CNT_BITS'(1);
        end
    end

    // The error flags are sticky until err_clr. A new error in the same cycle as err_clr still wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (WEN & full & ~clear)  | (overflow  & ~err_clr);
            underflow <= (REN & empty & ~clear) | (underflow & ~err_clr);
        end
    end

    // Storage has no reset, and a flush leaves the stored words in place.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

    generate
        if (FWFT == REG_MODE) begin : g_reg
            // Registered read: data and valid appear one cycle after an accepted read, and rdata holds otherwise.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else if (rd_acc) begin
                    rdata  <= mem[rd_ptr];
                    rvalid <= 1'b1;
                end else begin
                    rvalid <= 1'b0;
                end
            end
        end else begin : g_fwft
            assign rdata  = mem[rd_ptr];
            assign rvalid = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_wm.sv
// Self-checking bench for fifo_wm. Instance a is DEPTH=10 in first-word-fall-through mode.
// Instance b is DEPTH=4 in registered-read mode. Both are checked against queue-based models.
module tb_fifo_wm;

    localparam int DW    = 32;
    localparam int DEP_A = 10;
    localparam int DEP_B = 4;
    localparam int CB_A  = $clog2(DEP_A + 1);
    localparam int CB_B  = $clog2(DEP_B + 1);

    logic clk = 1'b0;
    logic nrst;

    logic          clear_a, wen_a, ren_a, err_clr_a;
    logic [DW-1:0] wdata_a, rdata_a;
    logic          rvalid_a, empty_a, full_a, above_a, below_a, ovf_a, udf_a;
    logic [CB_A-1:0] hi_a, lo_a, count_a;

    logic          clear_b, wen_b, ren_b, err_clr_b;
    logic [DW-1:0] wdata_b, rdata_b;
    logic          rvalid_b, empty_b, full_b, above_b, below_b, ovf_b, udf_b;
    logic [CB_B-1:0] hi_b, lo_b, count_b;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic m_ovf_a, m_udf_a, m_ovf_b, m_udf_b;
    logic m_rv_b;
    logic [DW-1:0] m_rd_b;

    always #5 clk = ~clk;

    fifo_wm #(.DATA_WIDTH(DW), .DEPTH(DEP_A), .FWFT(1)) dut_a (
        .CLK(clk), .nRST(nrst), .clear(clear_a), .WEN(wen_a), .wdata(wdata_a),
        .REN(ren_a), .rdata(rdata_a), .rvalid(rvalid_a), .hi_mark(hi_a), .lo_mark(lo_a),
        .err_clr(err_clr_a), .count(count_a), .empty(empty_a), .full(full_a),
        .above_hi(above_a), .below_lo(below_a), .overflow(ovf_a), .underflow(udf_a)
    );

    fifo_wm #(.DATA_WIDTH(DW), .DEPTH(DEP_B), .FWFT(0)) dut_b (
        .CLK(clk), .nRST(nrst), .clear(clear_b), .WEN(wen_b), .wdata(wdata_b),
        .REN(ren_b), .rdata(rdata_b), .rvalid(rvalid_b), .hi_mark(hi_b), .lo_mark(lo_b),
        .err_clr(err_clr_b), .count(count_b), .empty(empty_b), .full(full_b),
        .above_hi(above_b), .below_lo(below_b), .overflow(ovf_b), .underflow(udf_b)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputA();
        int n;
        n = qa.size();
        check("a_count", DW'(count_a), DW'(n));
        check("a_empty", DW'(empty_a), DW'(n == 0));
        check("a_full", DW'(full_a), DW'(n == DEP_A));
        check("a_above_hi", DW'(above_a), DW'(n >= int'(hi_a)));
        check("a_below_lo", DW'(below_a), DW'(n <= int'(lo_a)));
        check("a_overflow", DW'(ovf_a), DW'(m_ovf_a));
        check("a_underflow", DW'(udf_a), DW'(m_udf_a));
        check("a_rvalid", DW'(rvalid_a), DW'(n != 0));
        if (n != 0) check("a_rdata", rdata_a, qa[0]);
    endtask

    task automatic checkOutputB();
        int n;
        n = qb.size();
        check("b_count", DW'(count_b), DW'(n));
        check("b_empty", DW'(empty_b), DW'(n == 0));
        check("b_full", DW'(full_b), DW'(n == DEP_B));
        check("b_above_hi", DW'(above_b), DW'(n >= int'(hi_b)));
        check("b_below_lo", DW'(below_b), DW'(n <= int'(lo_b)));
        check("b_overflow", DW'(ovf_b), DW'(m_ovf_b));
        check("b_underflow", DW'(udf_b), DW'(m_udf_b));
        check("b_rvalid", DW'(rvalid_b), DW'(m_rv_b));
        check("b_rdata", rdata_b, m_rd_b);
    endtask

    // One clock cycle on instance a. The model decides acceptance from its occupancy before the edge.
    task automatic applyStimulusA(input logic w, input logic [DW-1:0] d, input logic r,
                                  input logic c, input logic e);
        logic was_full, was_empty;
        was_full  = (qa.size() == DEP_A);
        was_empty = (qa.size() == 0);
        wen_a = w; wdata_a = d; ren_a = r; clear_a = c; err_clr_a = e;
        @(posedge clk); #1;
        if (c) begin
            qa.delete();
        end else begin
            if (r && !was_empty) void'(qa.pop_front());
            if (w && !was_full) qa.push_back(d);
        end
        m_ovf_a = (w && was_full && !c) ? 1'b1 : (m_ovf_a && !e);
        m_udf_a = (r && was_empty && !c) ? 1'b1 : (m_udf_a && !e);
        wen_a = 0; ren_a = 0; clear_a = 0; err_clr_a = 0;
        checkOutputA();
    endtask

    // One clock cycle on instance b. In registered mode the popped word appears on the next cycle.
    task automatic applyStimulusB(input logic w, input logic [DW-1:0] d, input logic r);
        logic was_full, was_empty;
        was_full  = (qb.size() == DEP_B);
        was_empty = (qb.size() == 0);
        wen_b = w; wdata_b = d; ren_b = r;
        @(posedge clk); #1;
        m_rv_b = 1'b0;
        if (r && !was_empty) begin
            m_rd_b = qb.pop_front();
            m_rv_b = 1'b1;
        end
        if (w && !was_full) qb.push_back(d);
        m_ovf_b = m_ovf_b | (w && was_full);
        m_udf_b = m_udf_b | (r && was_empty);
        wen_b = 0; ren_b = 0;
        checkOutputB();
    endtask

    task automatic resetModels();
        qa.delete(); qb.delete();
        m_ovf_a = 0; m_udf_a = 0; m_ovf_b = 0; m_udf_b = 0;
        m_rv_b = 0; m_rd_b = '0;
    endtask

    initial begin
        nrst = 0;
        clear_a = 0; wen_a = 0; ren_a = 0; err_clr_a = 0; wdata_a = '0; hi_a = 0; lo_a = 2;
        clear_b = 0; wen_b = 0; ren_b = 0; err_clr_b = 0; wdata_b = '0; hi_b = 3; lo_b = 1;
        resetModels();
        #12;
        checkOutputA();
        checkOutputB();
        hi_a = 7;
        #1;
        checkOutputA();
        nrst = 1;

        // Fill to full, overflow, drain in order, underflow, clear errors
        for (int i = 0; i < DEP_A; i++) applyStimulusA(1, DW'(32'hA0 + i), 0, 0, 0);
        applyStimulusA(1, 32'hAA, 0, 0, 0);
        for (int i = 0; i < DEP_A; i++) applyStimulusA(0, '0, 1, 0, 0);
        applyStimulusA(0, '0, 1, 0, 0);
        applyStimulusA(0, '0, 0, 0, 1);

        // Pointer wrap with alternating write/read
        for (int i = 0; i < 25; i++) begin
            applyStimulusA(1, DW'(32'h100 + i), 0, 0, 0);
            applyStimulusA(0, '0, 1, 0, 0);
        end

        // Simultaneous read/write at count 5, then at full
        for (int i = 0; i < 5; i++) applyStimulusA(1, DW'(32'h200 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulusA(1, DW'(32'h300 + i), 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulusA(1, DW'(32'h400 + i), 0, 0, 0);
        applyStimulusA(1, 32'h4FF, 1, 0, 0);
        applyStimulusA(0, '0, 0, 1, 1);

        // Watermarks: rise to 7, drain to 2, retune hi_mark at count 5
        for (int i = 0; i < 7; i++) applyStimulusA(1, DW'(32'h500 + i), 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulusA(0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulusA(1, DW'(32'h600 + i), 0, 0, 0);
        hi_a = 3;
        #1;
        checkOutputA();

        // Flush at count 6 with a write; then err_clr with a write on full
        applyStimulusA(1, 32'h700, 0, 0, 0);
        applyStimulusA(1, 32'h701, 0, 1, 0);
        for (int i = 0; i < DEP_A; i++) applyStimulusA(1, DW'(32'h800 + i), 0, 0, 0);
        applyStimulusA(1, 32'h8FF, 0, 0, 0);
        applyStimulusA(1, 32'h8FE, 0, 0, 1);

        // Randomized traffic, write-heavy then read-heavy
        for (int i = 0; i < 300; i++) begin
            logic w, r, c, e;
            if (i % 25 == 0) begin
                hi_a = CB_A'($urandom_range(0, 15));
                lo_a = CB_A'($urandom_range(0, 15));
            end
            w = (i < 150) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
            r = (i < 150) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            c = ($urandom % 20 == 0);
            e = ($urandom % 10 == 0);
            applyStimulusA(w, DW'($urandom), r, c, e);
        end

        // Registered-read instance: two words, two reads, then idle
        applyStimulusB(1, 32'h11, 0);
        applyStimulusB(1, 32'h22, 0);
        applyStimulusB(0, '0, 1);
        applyStimulusB(0, '0, 1);
        applyStimulusB(0, '0, 0);
        for (int i = 0; i < 80; i++) begin
            applyStimulusB(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
        end

        // Mid-burst asynchronous reset
        applyStimulusB(1, 32'h33, 0);
        applyStimulusB(1, 32'h44, 1);
        applyStimulusB(1, 32'h55, 1);
        wen_b = 1; ren_b = 1; wdata_b = 32'h66;
        #3;
        nrst = 0;
        #1;
        resetModels();
        check("rst_b_count", DW'(count_b), '0);
        check("rst_b_empty", DW'(empty_b), DW'(1));
        check("rst_b_rvalid", DW'(rvalid_b), '0);
        checkOutputB();
        checkOutputA();
        wen_b = 0; ren_b = 0;
        #2;
        nrst = 1;
        applyStimulusB(0, '0, 1);
        applyStimulusA(0, '0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wm.md
Name: fifo_wm

Overview:
- Parametrised synchronous FIFO with any-integer depth (not limited to powers of two) and configurable data width.
- Both high and low watermark flags are runtime-programmable.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through or registered read mode.
- Serves as the buffering block behind peripheral RX/TX paths (UART, SPI, I2C) and feeds threshold flags to the interrupt logic.

Parameters:
- DATA_WIDTH, 32, width of wdata/rdata in bits.
- DEPTH, 16, number of entries; any integer >= 2.
- FWFT, 1, read mode. 1 = head word visible on rdata whenever not empty. 0 = rdata registered, valid one cycle after an accepted read.
- CNT_BITS, $clog2(DEPTH+1), derived localparam; width of count and of the watermark inputs.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- WEN  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- REN  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata valid.
- hi_mark  in  CNT_BITS  high watermark.
- lo_mark  in  CNT_BITS  low watermark.
- err_clr  in  1  clears sticky error flags.
- count  out  CNT_BITS  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- above_hi  out  1  count >= hi_mark.
- below_lo  out  1  count <= lo_mark.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: one clock, CLK; asynchronous active-low reset, nRST. Storage, pointers and every register are on the CLK rising edge; there is no negedge logic.
- Reset values:
  - count=0, pointers=0, empty=1, full=0, overflow=0, underflow=0, rvalid=0, rdata=0.
  - above_hi and below_lo are combinational from count, so at reset above_hi=(hi_mark==0) and below_lo=1.
  - Storage array is not reset.
- Accept rules:
  - wr_acc = WEN & !full & !clear.
  - rd_acc = REN & !empty & !clear.
  - full and empty are evaluated from the registered count before the edge. A write to a full FIFO is rejected even when a read is accepted in the same cycle.
- Pointer wrap: wr_ptr and rd_ptr step 0..DEPTH-1 and wrap DEPTH-1 -> 0. Compare against DEPTH-1 explicitly; never rely on natural binary overflow.
- Count update:
  - wr_acc only: +1. rd_acc only: -1. Both or neither: unchanged.
  - Count never leaves 0..DEPTH.
- Data path:
  - On wr_acc, mem[wr_ptr] <= wdata.
  - Simultaneous read and write at the same index cannot occur, because equal pointers imply empty or full.
- Read modes:
  - FWFT=1: rdata = mem[rd_ptr] combinationally and rvalid = !empty. rdata is don't-care when empty; the bench must not check it then.
  - FWFT=0: on rd_acc, rdata <= mem[rd_ptr] and rvalid <= 1; otherwise rvalid <= 0 and rdata holds its previous value.
- Latency: a word written in cycle N is readable (empty=0) from cycle N+1.
- Flush: clear=1 sets pointers and count to 0 at the next edge and overrides WEN/REN in that cycle. Sticky error flags, rdata and storage are untouched; in FWFT=0 mode rvalid <= 0.
- Sticky errors:
  - overflow sets on WEN & full & !clear.
  - underflow sets on REN & empty & !clear.
  - err_clr clears both flags. If a set condition and err_clr occur in the same cycle, set wins.
- Watermark compares are unsigned on CNT_BITS. Watermark changes take effect combinationally. hi_mark > DEPTH means above_hi is never asserted.
- Mid-operation reset: nRST low at any point returns all registers immediately to their reset values. Pending reads/writes are dropped.

Decomposition:
- Package fifo_pkg holds the read-mode constants FWFT_MODE=1 and REG_MODE=0, used by the FWFT parameter.
- Sub-module fifo_wrap_ptr (params MAX, WIDTH; ports CLK, nRST, clear, inc, ptr) is instantiated twice, once for the write pointer and once for the read pointer.
- Count, flags and storage stay in the top module.

Test Plan (DEPTH=10 unless noted):
- Fill and drain: write 10 words 0xA0..0xA9 with no reads -> full=1 and count=10 after the 10th edge; 11th WEN -> word dropped, overflow=1. Read all 10 -> data returned 0xA0..0xA9 in order, empty=1, then REN -> underflow=1.
- Wrap: run 25 alternating write/read pairs -> pointers wrap past 9 to 0 twice, count stays 0/1, data in order, no error flags.
- Simultaneous: count=5, WEN=REN=1 for 3 cycles -> count stays 5, reads return the oldest three words. At count=10, WEN=REN=1 -> read accepted, write rejected, count=9, overflow=1.
- Watermarks: hi_mark=7, lo_mark=2; write up to 7 -> above_hi rises as count reaches 7. Drain to 2 -> below_lo rises at count 2. Change hi_mark to 3 at count 5 -> above_hi=1 in the same cycle.
- Flush and errors: count=6, assert clear together with WEN -> count=0 and empty=1 next cycle, write not stored, overflow unchanged. Assert err_clr together with WEN on a full FIFO -> overflow stays 1.
- FWFT=0 with DEPTH=4: write 0x11 and 0x22, then REN for 2 cycles -> rvalid high on the two following cycles, carrying 0x11 then 0x22. Assert nRST mid-burst -> count=0, empty=1, rvalid=0 immediately.
